// File: rtl/usr_pkg.sv
// Shared types and helpers for the universal shift sequencer (usr_seq).
package usr_pkg;

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_SHR   = 3'd1,
        OP_SHL   = 3'd2,
        OP_LOAD  = 3'd3,
        OP_ROR   = 3'd4,
        OP_ROL   = 3'd5,
        OP_ASR   = 3'd6,
        OP_CLEAR = 3'd7
    } op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Shifts saturate at the register width; rotates wrap, since a full turn is a no-op.
    function automatic int unsigned eff_amt(op_e op, int unsigned amt, int unsigned width);
        case (op)
            OP_SHR, OP_SHL, OP_ASR: return (amt > width) ? width : amt;
            OP_ROR, OP_ROL:         return amt % width;
            default:                return 0;
        endcase
    endfunction

endpackage

// File: rtl/usr_if.sv
// Command/serial/status bundle between a controller and usr_seq.
interface usr_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AMT_W = $clog2(WIDTH) + 1
) ();
    logic              cmd_valid;
    logic              cmd_ready;
    usr_pkg::op_e      cmd_op;
    logic [AMT_W-1:0]  cmd_amt;
    logic [WIDTH-1:0]  cmd_data;
    logic              sin_r;
    logic              sin_l;
    logic              abort;
    logic [WIDTH-1:0]  q;
    logic              sout_r;
    logic              sout_l;
    logic              busy;
    logic              done;

    modport master (
        output cmd_valid, cmd_op, cmd_amt, cmd_data, sin_r, sin_l, abort,
        input  cmd_ready, q, sout_r, sout_l, busy, done
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_amt, cmd_data, sin_r, sin_l, abort,
        output cmd_ready, q, sout_r, sout_l, busy, done
    );
endinterface

// File: rtl/usr_step.sv
// Single-step next-value function for the shift/rotate ops; other ops hold q.
module usr_step
    import usr_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  op_e              op,
    input  logic             sin_r,
    input  logic             sin_l,
    output logic [WIDTH-1:0] q_next
);

    always_comb begin
        // NOTE: assign a default before the case so every path drives q_next; otherwise a latch is inferred.
        q_next = q;
        case (op)
            OP_SHR:  q_next = {sin_r, q[WIDTH-1:1]};
            OP_SHL:  q_next = {q[WIDTH-2:0], sin_l};
            OP_ROR:  q_next = {q[0], q[WIDTH-1:1]};
            OP_ROL:  q_next = {q[WIDTH-2:0], q[WIDTH-1]};
            OP_ASR:  q_next = {q[WIDTH-1], q[WIDTH-1:1]};
            default: q_next = q;
        endcase
    end

endmodule

// File: rtl/usr_seq.sv
// Parametrised universal shift register: one bit per clock, with load/clear, abort and done pulse.
module usr_seq
    import usr_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AMT_W = $clog2(WIDTH) + 1
) (
    input  logic  clk,
    input  logic  rst,
    usr_if.slave  bus
);

    state_e           state, state_n;
    op_e              op_r, op_n;
    logic [AMT_W-1:0] cnt, cnt_n;
    logic [WIDTH-1:0] q_r, q_n, q_step;
    logic             done_r, done_n;
    logic [AMT_W-1:0] eff;

    assign eff = AMT_W'(eff_amt(bus.cmd_op, 32'(bus.cmd_amt), WIDTH));

    usr_step #(.WIDTH(WIDTH)) u_step (
        .q      (q_r),
        .op     (op_r),
        .sin_r  (bus.sin_r),
        .sin_l  (bus.sin_l),
        .q_next (q_step)
    );

    always_comb begin
        state_n = state;
        op_n    = op_r;
        cnt_n   = cnt;
        q_n     = q_r;
        done_n  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    case (bus.cmd_op)
                        OP_NOP:   done_n = 1'b1;
                        OP_LOAD:  begin q_n = bus.cmd_data; done_n = 1'b1; end
                        OP_CLEAR: begin q_n = '0;           done_n = 1'b1; end
                        default: begin
                            if (eff == '0) begin
                                done_n = 1'b1;
                            end else begin
                                state_n = ST_RUN;
                                op_n    = bus.cmd_op;
                                cnt_n   = eff;
                            end
                        end
                    endcase
                end
            end
            ST_RUN: begin
                // The final step always lands; abort only decides whether done is reported.
                if (cnt == AMT_W'(1)) begin
                    q_n     = q_step;
                    cnt_n   = '0;
                    state_n = ST_IDLE;
                    done_n  = ~bus.abort;
                end else if (bus.abort) begin
                    cnt_n   = '0;
                    state_n = ST_IDLE;
                end else begin
                    q_n   = q_step;
                    cnt_n = cnt - AMT_W'(1);
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            op_r   <= OP_NOP;
            cnt    <= '0;
            q_r    <= '0;
            done_r <= 1'b0;
        end else begin
            state  <= state_n;
            op_r   <= op_n;
            cnt    <= cnt_n;
            q_r    <= q_n;
            done_r <= done_n;
        end
    end

    assign bus.cmd_ready = (state == ST_IDLE);
    assign bus.busy      = (state == ST_RUN);
    assign bus.q         = q_r;
    assign bus.sout_r    = q_r[0];
    assign bus.sout_l    = q_r[WIDTH-1];
    assign bus.done      = done_r;

endmodule

// File: doc/usr_seq.md
Name: usr_seq

Overview:
- Parametrised universal shift register with a command handshake. Performs multi-step shift/rotate operations at one bit per clock, plus parallel load and clear.
- Successor to the fixed 4-bit universal shift register. Adds generic WIDTH, rotate and arithmetic modes, programmable shift amount, busy/done signalling and abort.
- Sits between a control FSM (command source) and serial/parallel datapaths (serialisers, CRC/LFSR feeders, bit-bang engines).

Parameters:
- WIDTH, 8, register width in bits; must be >= 2.
- AMT_W, $clog2(WIDTH)+1, width of the shift-amount field; must be able to encode WIDTH.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command (= state IDLE)
- cmd_op  in  3  operation code (see Behaviour)
- cmd_amt  in  AMT_W  number of single-bit steps
- cmd_data  in  WIDTH  parallel load value
- sin_r  in  1  serial input entering at the MSB on right shifts
- sin_l  in  1  serial input entering at the LSB on left shifts
- abort  in  1  terminate a running operation
- q  out  WIDTH  register contents
- sout_r  out  1  = q[0] (bit leaving on the next right shift)
- sout_l  out  1  = q[WIDTH-1] (bit leaving on the next left shift)
- busy  out  1  multi-step operation in progress (= state RUN)
- done  out  1  one-cycle pulse, command completed

Behaviour:
- Reset (rst=1 at an edge): q=0, state IDLE, counter=0, done=0. Therefore busy=0 and cmd_ready=1. Reset overrides abort and commands and takes effect mid-operation.
- Ops: 0 NOP, 1 SHR (q<={sin_r,q[W-1:1]}), 2 SHL (q<={q[W-2:0],sin_l}), 3 LOAD (q<=cmd_data), 4 ROR, 5 ROL, 6 ASR (MSB replicated), 7 CLEAR (q<=0).
- Accept = cmd_valid & cmd_ready at a rising edge. Inputs are ignored while cmd_ready=0; there is no queueing.
- NOP, LOAD, CLEAR: q is updated at the accept edge. done=1 for the following cycle. State stays IDLE.
- SHR/SHL/ASR: effective amount = min(cmd_amt, WIDTH).
- ROR/ROL: effective amount = cmd_amt mod WIDTH.
- Effective amount 0: q unchanged, done next cycle, stays IDLE.
- Effective amount N >= 1: the accept edge latches op and N into the counter and moves to RUN. q is not changed at the accept edge.
- In RUN, each edge performs one step and decrements the counter. The edge where counter==1 performs the last step and returns to IDLE.
- done is high in the cycle after the final step, coincident with cmd_ready=1. A new command may be accepted in that same cycle.
- Total timing: accept at edge 0, q updated at edges 1..N, done during cycle N+1.
- sin_r/sin_l are sampled live at every step edge; they are not latched at accept.
- abort=1 at an edge in RUN: go to IDLE, q keeps its partial result, no done pulse.
- abort has no effect in IDLE, and a command accepted in the same cycle as abort in IDLE proceeds normally.
- Abort coinciding with the final step edge: the step executes, the block goes IDLE, done is suppressed.
- sout_r/sout_l are combinational from q.

Decomposition:
- Package usr_pkg:
  - op_e enum (OP_NOP..OP_CLEAR, 3 bits)
  - state_e enum (ST_IDLE, ST_RUN)
  - function for effective-amount clamp/modulo
- Sub-module usr_step: combinational single-step next-value function.
  - Inputs: q, op, sin_r, sin_l. Output: q_next.
  - Instantiated once.
  - Unit-testable exhaustively for small WIDTH.

Test Plan:
All scenarios use WIDTH=8.
- Reset: hold rst=1 two cycles with cmd_valid=1, op=LOAD -> q=0x00, busy=0, cmd_ready=1, done=0 throughout.
- LOAD 0xA5 -> q=0xA5 next cycle, done=1 for exactly one cycle, busy never asserted.
- From 0xA5, ROL amt=3 -> q=0x4B, 0x96, 0x2D on successive edges; busy=1 for 3 cycles; done in the 4th cycle. ROR amt=8 -> no change, done next cycle.
- ASR amt=7 from 0x80 -> q=0xFF after 7 steps. SHL amt=12 from 0x00 with sin_l=1 -> clamped to 8 steps, q=0xFF, done 9 cycles after accept.
- SHR amt=5 from 0xF0, sin_r=0, abort after 2 steps -> q=0x3C, no done, cmd_ready=1 next cycle. A second cmd_valid held during busy is not accepted.
- rst=1 asserted mid-ROL -> next cycle q=0, busy=0, done=0. Then a back-to-back command issued in the done cycle -> accepted with no bubble.
